// File: rtl/ultrascan_report_collector_if.sv
// Record stream from the report collector toward the host-facing writer.
// Each record is {report vector, symbol offset}; valid/ready handshake.
interface ultrascan_report_collector_if #(
  parameter int N_RPT    = 1,
  parameter int OFFSET_W = 32
);
  logic                      out_valid;
  logic                      out_ready;
  logic [N_RPT+OFFSET_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/ultrascan_report_collector.sv
// Tags automaton reports with the offset of the triggering symbol and queues
// the resulting records in a first-word-fall-through FIFO.
module ultrascan_report_collector #(
  parameter int N_RPT    = 1,
  parameter int OFFSET_W = 32,
  parameter int DEPTH    = 16,
  parameter int DROP_W   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         clear,
  input  logic [N_RPT-1:0]             report,
  ultrascan_report_collector_if.master rec,
  output logic [$clog2(DEPTH):0]       fifo_count,
  output logic                         overflow,
  output logic [DROP_W-1:0]            drop_count
);
  localparam int REC_W = N_RPT + OFFSET_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [OFFSET_W-1:0] sym_off_reg;
  logic [OFFSET_W-1:0] off_d_reg;
  logic                run_d_reg;
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                overflow_reg;
  logic [DROP_W-1:0]   drop_reg;
  logic [REC_W-1:0]    mem_reg [DEPTH];

  logic              capture;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [REC_W-1:0]  record;
  logic [DEPTH-1:0]  wr_en;

  // Reports are one cycle behind the symbol, so gate them with the delayed run
  // and pair them with the delayed offset; a stalled automaton is never re-captured.
  assign capture = run_d_reg & (|report);
  assign record  = {report, off_d_reg};
  assign full    = (count_reg == FULL_CNT);
  assign pop     = rec.out_valid & rec.out_ready;
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  assign rec.out_valid = (count_reg != '0);
  assign rec.out_data  = mem_reg[rd_ptr_reg];
  assign fifo_count    = count_reg;
  assign overflow      = overflow_reg;
  assign drop_count    = drop_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push & ~clear & (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // When full with a simultaneous pop, wr_ptr equals rd_ptr: the slot being
  // read this cycle is overwritten at the edge and becomes the newest entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          mem_reg[i] <= record;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_off_reg  <= '0;
      off_d_reg    <= '0;
      run_d_reg    <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      drop_reg     <= '0;
    end else if (clear) begin
      sym_off_reg  <= '0;
      off_d_reg    <= '0;
      run_d_reg    <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      drop_reg     <= '0;
    end else begin
      run_d_reg <= run;
      off_d_reg <= sym_off_reg;
      if (run) begin
        sym_off_reg <= sym_off_reg + OFFSET_W'(1);
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_reg != DROP_MAX) begin
          drop_reg <= drop_reg + DROP_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_ultrascan_report_collector.sv
// Directed bench for the report collector: 2 report lines, 8-bit offsets,
// 16-entry FIFO; records are {report[1:0], offset[7:0]}.
module tb_ultrascan_report_collector;
  localparam int N_RPT    = 2;
  localparam int OFFSET_W = 8;
  localparam int DEPTH    = 16;
  localparam int DROP_W   = 16;

  logic              clk;
  logic              reset;
  logic              run;
  logic              clear;
  logic [N_RPT-1:0]  report;
  logic [4:0]        fifo_count;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  int checks = 0;
  int errors = 0;

  ultrascan_report_collector_if #(.N_RPT(N_RPT), .OFFSET_W(OFFSET_W)) rec_if ();

  ultrascan_report_collector #(
    .N_RPT(N_RPT), .OFFSET_W(OFFSET_W), .DEPTH(DEPTH), .DROP_W(DROP_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .run(run),
    .clear(clear),
    .report(report),
    .rec(rec_if),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    rec_if.out_ready = 1'b1;
    step();
    rec_if.out_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; run = 1'b0; report = '0;
    step();
    clear = 1'b0;
  endtask

  // 17 captures (offsets 0..16) into a 16-deep FIFO, then drain 13 -> 13,14,15 remain.
  task automatic fill_and_partial_drain();
    do_clear();
    for (int k = 0; k < 18; k++) begin
      run = 1'b1; report = 2'b01;
      step();
    end
    run = 1'b0; report = '0;
    check("fill_count", 32'(fifo_count), 32'd16);
    check("fill_drop", 32'(drop_count), 32'd1);
    for (int k = 0; k < 13; k++) pop_one();
    check("part_count", 32'(fifo_count), 32'd3);
    check("part_ovf", 32'(overflow), 32'd1);
    check("part_data", 32'(rec_if.out_data), 32'h10D);
  endtask

  // One symbol, report on the following cycle -> record {01, offset 0}.
  task automatic first_symbol_after_restart(input string tag);
    run = 1'b1; report = '0;
    step();
    run = 1'b0; report = 2'b01;
    step();
    report = '0;
    check({tag, "_count"}, 32'(fifo_count), 32'd1);
    check({tag, "_data"}, 32'(rec_if.out_data), 32'h100);
    pop_one();
    check({tag, "_empty"}, 32'(fifo_count), 32'd0);
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; clear = 1'b0; report = '0;
    rec_if.out_ready = 1'b0;
    step();
    step();
    check("rst_valid", 32'(rec_if.out_valid), 32'd0);
    check("rst_data", 32'(rec_if.out_data), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    reset = 1'b1;

    // 1: five symbols, report for symbol 3
    for (int i = 0; i < 5; i++) begin
      run = 1'b1; report = (i == 4) ? 2'b01 : 2'b00;
      step();
    end
    run = 1'b0; report = '0;
    check("t1_valid", 32'(rec_if.out_valid), 32'd1);
    check("t1_count", 32'(fifo_count), 32'd1);
    check("t1_data", 32'(rec_if.out_data), 32'h103);
    check("t1_symoff", 32'(dut.sym_off_reg), 32'd5);
    pop_one();
    check("t1_popcount", 32'(fifo_count), 32'd0);
    check("t1_popvalid", 32'(rec_if.out_valid), 32'd0);

    // 2: stall with report held high
    do_clear();
    check("t2_clrsym", 32'(dut.sym_off_reg), 32'd0);
    run = 1'b1; report = '0;
    step();
    for (int i = 0; i < 3; i++) begin
      run = 1'b0; report = 2'b01;
      step();
      check("t2_symoff", 32'(dut.sym_off_reg), 32'd1);
    end
    report = '0;
    check("t2_count", 32'(fifo_count), 32'd1);
    check("t2_data", 32'(rec_if.out_data), 32'h100);
    pop_one();
    check("t2_empty", 32'(fifo_count), 32'd0);

    // 3: 18 reports into a 16-deep FIFO with out_ready low
    do_clear();
    for (int k = 0; k < 18; k++) begin
      run = 1'b1; report = (k > 0) ? 2'b01 : 2'b00;
      step();
    end
    run = 1'b0; report = 2'b01;
    step();
    report = '0;
    check("t3_count", 32'(fifo_count), 32'd16);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_drop", 32'(drop_count), 32'd2);

    // 4: full, capture and pop together (offset 18 joins the tail)
    run = 1'b1; report = '0;
    step();
    run = 1'b0; report = 2'b01; rec_if.out_ready = 1'b1;
    check("t4_head", 32'(rec_if.out_data), 32'h100);
    step();
    report = '0;
    check("t4_count", 32'(fifo_count), 32'd16);
    check("t4_drop", 32'(drop_count), 32'd2);
    check("t4_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("t4_dvalid", 32'(rec_if.out_valid), 32'd1);
      check("t4_drain", 32'(rec_if.out_data), (i < 15) ? 32'h100 + 32'(i + 1) : 32'h112);
      step();
    end
    rec_if.out_ready = 1'b0;
    check("t4_empty", 32'(fifo_count), 32'd0);
    check("t4_valid0", 32'(rec_if.out_valid), 32'd0);

    // 5: offset wrap 255 -> 0, multi-bit reports share one record
    do_clear();
    for (int k = 0; k < 257; k++) begin
      run = 1'b1; report = (k == 256) ? 2'b11 : 2'b00;
      step();
    end
    run = 1'b0; report = 2'b10;
    step();
    report = '0;
    check("t5_count", 32'(fifo_count), 32'd2);
    check("t5_rec255", 32'(rec_if.out_data), 32'h3FF);
    pop_one();
    check("t5_rec0", 32'(rec_if.out_data), 32'h200);
    pop_one();
    check("t5_empty", 32'(fifo_count), 32'd0);

    // 6a: clear with records queued, capture pending in the clear cycle
    fill_and_partial_drain();
    run = 1'b1; report = '0;
    step();
    clear = 1'b1; run = 1'b0; report = 2'b01;
    step();
    clear = 1'b0; report = '0;
    check("t6c_valid", 32'(rec_if.out_valid), 32'd0);
    check("t6c_count", 32'(fifo_count), 32'd0);
    check("t6c_ovf", 32'(overflow), 32'd0);
    check("t6c_drop", 32'(drop_count), 32'd0);
    first_symbol_after_restart("t6c");

    // 6b: same with asynchronous reset mid-stream
    fill_and_partial_drain();
    run = 1'b1; report = '0;
    step();
    report = 2'b01;
    #2 reset = 1'b0;
    #1;
    check("t6r_valid", 32'(rec_if.out_valid), 32'd0);
    check("t6r_count", 32'(fifo_count), 32'd0);
    check("t6r_ovf", 32'(overflow), 32'd0);
    check("t6r_drop", 32'(drop_count), 32'd0);
    check("t6r_data", 32'(rec_if.out_data), 32'd0);
    check("t6r_symoff", 32'(dut.sym_off_reg), 32'd0);
    step();
    reset = 1'b1; run = 1'b0; report = 2'b01;
    step();
    report = '0;
    check("t6r_nocap", 32'(fifo_count), 32'd0);
    first_symbol_after_restart("t6r");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ultrascan_report_collector.md
Name: ultrascan_report_collector

Overview:
Downstream consumer of a generated Automata_* block. Tracks the byte offset of every symbol fed to the automaton. Captures the automaton's report outputs together with the offset of the symbol that triggered them, and buffers the resulting report records in a FIFO. Drains the records over a valid/ready stream toward the kernel's host-facing writer.

Parameters:
N_RPT, 1, number of report lines from the automaton (report vector width)
OFFSET_W, 32, width of the symbol offset counter and of the offset field in a record
DEPTH, 16, FIFO entries; power of 2, minimum 2
DROP_W, 16, width of the saturating dropped-record counter

Ports:
clk  input  1  rising-edge clock shared with the automaton
reset  input  1  asynchronous, active-low reset (0 = in reset)
run  input  1  same run strobe driven to the automaton; 1 = a symbol is consumed this cycle
clear  input  1  synchronous clear of offset, FIFO and status
report  input  N_RPT  automaton report lines (STE active_state outputs)
out_valid  output  1  record available at out_data
out_ready  input  1  downstream accepts record
out_data  output  N_RPT+OFFSET_W  record = {report vector, symbol offset}
fifo_count  output  $clog2(DEPTH)+1  records currently held
overflow  output  1  sticky: at least one record dropped since reset/clear
drop_count  output  DROP_W  records dropped, saturating

Behaviour:
- Async reset (reset=0): sym_off, off_d, run_d, FIFO pointers, fifo_count, overflow and drop_count all 0. out_valid=0, out_data=0.
- Offset counter sym_off: +1 on each cycle with run=1; wraps 2^OFFSET_W-1 -> 0. The first symbol after reset or clear has offset 0.
- Alignment: STE outputs are registered, so a report for the symbol presented at cycle t appears at cycle t+1.
  - On every clk, run_d <= run and off_d <= sym_off (the pre-increment value).
  - Capture condition at cycle t+1: run_d=1 and |report=1.
  - report is ignored when run_d=0; a stalled automaton holds its state, so re-capture is prevented.
- Record: {report, off_d}. Report bits are MSBs; all simultaneous reports share one record.
- FIFO storage: circular register array with rd_ptr/wr_ptr and fifo_count. Latency from capture to out_valid is 1 cycle.
- Push: capture and (fifo_count<DEPTH, or a pop happens in the same cycle).
- Pop: out_valid and out_ready. out_data = entry at rd_ptr (first-word fall-through), stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop: fifo_count unchanged. This also applies when full: the incoming record is accepted.
- Full, capture, no pop:
  - record dropped;
  - overflow <= 1 (sticky);
  - drop_count +1, saturating at 2^DROP_W-1.
- Empty: out_valid=0; out_data holds the last value and is don't-care.
- clear=1 (sync, highest priority over push/pop/count):
  - resets sym_off, run_d, off_d, pointers, fifo_count, overflow and drop_count to 0;
  - any capture in that cycle is discarded;
  - out_valid=0 next cycle.
- Reset asserted mid-stream: all state discarded immediately; no partial record emitted after release.
- Pointer wrap at DEPTH-1 -> 0 on both pointers.

Test Plan:
1. Run 5 symbols (run=1 for cycles 0-4); report=1 in the cycle after symbol 3 -> one record {1, 32'd3}, out_valid=1 one cycle later, fifo_count=1; out_ready=1 pops it and fifo_count=0.
2. Stall: run=1, then run=0 for 3 cycles while report is held at 1 -> exactly one record, with offset 0; sym_off stays 1 during the stall.
3. out_ready=0; 18 reports on consecutive symbols with DEPTH=16 -> fifo_count=16, overflow=1, drop_count=2. Draining yields offsets 0..15 in order.
4. FIFO full, capture and pop in the same cycle -> count stays 16, no drop, new record appears last.
5. Preload sym_off by running 2^OFFSET_W-1 symbols (OFFSET_W=8 build: 255 symbols), then report on the next two -> offsets 255 and 0.
6. 3 records queued, overflow=1; pulse clear -> next cycle out_valid=0, fifo_count=0, overflow=0, drop_count=0. The next symbol's report carries offset 0. Repeat the sequence with reset=0 instead of clear for the same result.
